// File: rtl/img_pixel_streamer.sv
// Raster-order frame reader: streams a stored image out of a 1-cycle-latency frame RAM
// as valid/ready pixel beats with sof/eol/eof. Define IMG_STREAM_MIRROR_EN for horizontal mirroring.
module img_pixel_streamer #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              sof,
    output logic              eol,
    output logic              eof
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nx;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              last_col, last_pix;
    logic [ADDR_W-1:0] rd_addr;

    // Two-entry skid buffer; flags packed as {sof, eol, eof}
    logic [PIX_W-1:0]  buf_pix [2];
    logic [2:0]        buf_flg [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;
    logic              inflight;
    logic [2:0]        inflight_flg;
    logic              pop;
    logic [1:0]        occ;

    assign last_col = (col == COL_W'(IMG_W - 1));
    assign last_pix = last_col && (row == ROW_W'(IMG_H - 1));

    assign pix_valid = (count != 2'd0);
    assign pop       = pix_valid & pix_ready;
    // Entries held or arriving after this cycle's pop; a new read is allowed only below 2
    assign occ       = count + {1'b0, inflight} - {1'b0, pop};

    assign pix_out  = pix_valid ? buf_pix[rd_ptr] : '0;
    assign sof      = pix_valid & buf_flg[rd_ptr][2];
    assign eol      = pix_valid & buf_flg[rd_ptr][1];
    assign eof      = pix_valid & buf_flg[rd_ptr][0];
    assign mem_addr = mem_rd_en ? rd_addr : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (mem_rd_en && last_pix) state_nx = S_DRAIN;
            S_DRAIN: if (occ == 2'd0) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        case (state)
            S_RUN: begin
                busy      = 1'b1;
                mem_rd_en = (occ < 2'd2);
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

`ifdef IMG_STREAM_MIRROR_EN
    logic [ADDR_W-1:0] line_base;
    logic [COL_W-1:0]  mir_col;

    assign rd_addr = line_base + ADDR_W'(mir_col);

    always_ff @(posedge clk) begin
        if (!rst_n || (state == S_IDLE && start)) begin
            line_base <= '0;
            mir_col   <= COL_W'(IMG_W - 1);
        end else if (mem_rd_en) begin
            if (last_col) begin
                line_base <= line_base + ADDR_W'(IMG_W);
                mir_col   <= COL_W'(IMG_W - 1);
            end else begin
                mir_col   <= mir_col - COL_W'(1);
            end
        end
    end
`else
    logic [ADDR_W-1:0] addr_q;

    assign rd_addr = addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n || (state == S_IDLE && start)) addr_q <= '0;
        else if (mem_rd_en)                       addr_q <= addr_q + ADDR_W'(1);
    end
`endif

    // col/row track beat position in both builds, so flags never depend on address order
    always_ff @(posedge clk) begin
        if (!rst_n || (state == S_IDLE && start)) begin
            col <= '0;
            row <= '0;
        end else if (mem_rd_en) begin
            if (last_col) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight     <= 1'b0;
            inflight_flg <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_pix[i] <= '0;
                buf_flg[i] <= '0;
            end
        end else begin
            inflight <= mem_rd_en;
            if (mem_rd_en)
                inflight_flg <= {(row == '0) && (col == '0), last_col, last_pix};
            if (inflight) begin
                buf_pix[wr_ptr] <= mem_rd_data;
                buf_flg[wr_ptr] <= inflight_flg;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_img_pixel_streamer.sv
// Directed bench for img_pixel_streamer on a 4x2 ramp image (mem[a] = a).
// Expected pixel order follows IMG_STREAM_MIRROR_EN when that macro is defined.
module tb_img_pixel_streamer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int AW = 8;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pix_ready = 1'b0;
    logic          busy, done, mem_rd_en, pix_valid, sof, eol, eof;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_rd_data = '0;
    logic [PW-1:0] pix_out;

    int checks = 0;
    int errors = 0;

    img_pixel_streamer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pix_out(pix_out), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .sof(sof), .eol(eol), .eof(eof)
    );

    always #5 clk = ~clk;

    // Ramp frame RAM with one cycle of read latency
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr;

    function automatic logic [7:0] exp_pix(input int b);
`ifdef IMG_STREAM_MIRROR_EN
        return 8'((b / W) * W + (W - 1 - (b % W)));
`else
        return 8'(b);
`endif
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change at posedge+1; outputs are sampled at posedge+4
    task automatic drive(input logic s, input logic r);
        start     = s;
        pix_ready = r;
        #3;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, ".busy"}, busy, 1'b0);
        chk1({tag, ".done"}, done, 1'b0);
        chk1({tag, ".rd_en"}, mem_rd_en, 1'b0);
        chk8({tag, ".addr"}, mem_addr, 8'd0);
        chk1({tag, ".valid"}, pix_valid, 1'b0);
        chk8({tag, ".pix"}, pix_out, 8'd0);
        chk1({tag, ".sof"}, sof, 1'b0);
        chk1({tag, ".eol"}, eol, 1'b0);
        chk1({tag, ".eof"}, eof, 1'b0);
    endtask

    task automatic chk_beat(input string tag, input int b);
        chk1({tag, ".valid"}, pix_valid, 1'b1);
        chk8({tag, ".pix"}, pix_out, exp_pix(b));
        chk1({tag, ".sof"}, sof, b == 0);
        chk1({tag, ".eol"}, eol, (b % W) == W - 1);
        chk1({tag, ".eof"}, eof, b == N - 1);
    endtask

    // Full frame with pix_ready high; optional second start pulse at cycle repulse
    task automatic run_full(input string tag, input int repulse);
        for (int c = 0; c < 14; c++) begin
            drive(c == 0 || c == repulse, 1'b1);
            chk1({tag, ".busy"}, busy, c >= 1 && c <= N + 2);
            chk1({tag, ".done"}, done, c == N + 3);
            chk1({tag, ".rd_en"}, mem_rd_en, c >= 1 && c <= N);
            if (c >= 1 && c <= N) chk8({tag, ".addr"}, mem_addr, exp_pix(c - 1));
            if (c >= 3 && c <= N + 2) chk_beat(tag, c - 3);
            else chk1({tag, ".idle_valid"}, pix_valid, 1'b0);
            adv();
        end
    endtask

    initial begin
        int          reads, beats, dones;
        logic        prev_stall;
        logic [7:0]  prev_pix;
        logic        pat [4];

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        adv();
        adv();
        drive(1'b0, 1'b0);
        chk_zero("reset");
        rst_n = 1'b1;
        adv();

        // Sustained streaming
        run_full("stream", -1);

        // Periodic back-pressure
        reads = 0; beats = 0; dones = 0; prev_stall = 1'b0; prev_pix = '0;
        for (int c = 0; c < 60 && dones == 0; c++) begin
            drive(c == 0, pat[c % 4]);
            if (prev_stall) begin
                chk1("stall.hold_valid", pix_valid, 1'b1);
                chk8("stall.hold_pix", pix_out, prev_pix);
            end
            if (mem_rd_en) begin
                chk8("stall.addr", mem_addr, exp_pix(reads));
                reads++;
            end
            if (pix_valid) chk_beat("stall", beats);
            prev_stall = pix_valid && !pix_ready;
            prev_pix   = pix_out;
            if (pix_valid && pix_ready) beats++;
            chk1("stall.outstanding", (reads - beats) <= 2, 1'b1);
            if (done) dones++;
            adv();
        end
        chki("stall.beats", beats, N);
        chki("stall.reads", reads, N);
        chki("stall.dones", dones, 1);
        drive(1'b0, 1'b1);
        chk1("stall.after_busy", busy, 1'b0);
        chk1("stall.after_done", done, 1'b0);
        adv();

        // Consumer held off for 20 cycles after start
        reads = 0;
        for (int c = 0; c <= 20; c++) begin
            drive(c == 0, 1'b0);
            if (mem_rd_en) reads++;
            if (c >= 3) begin
                chk1("held.valid", pix_valid, 1'b1);
                chk8("held.pix", pix_out, exp_pix(0));
                chk1("held.sof", sof, 1'b1);
            end
            adv();
        end
        chki("held.reads", reads, 2);
        for (int c = 21; c <= 30; c++) begin
            drive(1'b0, 1'b1);
            if (c <= 28) chk_beat("release", c - 21);
            else chk1("release.valid", pix_valid, 1'b0);
            chk1("release.done", done, c == 29);
            adv();
        end

        // start while busy is ignored; a later start replays from address 0
        run_full("repulse", 5);
        run_full("restart", -1);

        // Reset in the middle of a frame
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, 1'b1);
            if (c == 5) chk_beat("pre_rst", 2);
            adv();
        end
        rst_n = 1'b0;
        drive(1'b0, 1'b1);
        adv();
        rst_n = 1'b1;
        drive(1'b0, 1'b1);
        chk_zero("midrst");
        adv();
        drive(1'b0, 1'b1);
        chk1("midrst.busy2", busy, 1'b0);
        chk1("midrst.valid2", pix_valid, 1'b0);
        adv();
        run_full("after_rst", -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
